// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared op codes, FSM state encoding and op-decode helpers
// for the multiply/divide unit.
package md_unit_pkg;

  // Op codes presented by EXE on req_op
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Signed variants treat operands as two's complement
  function automatic logic md_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: EXE <-> multiply/divide unit handshake and result bus.
// master = EXE stage, slave = md_unit.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output req_valid, req_op, src1, src2, cancel,
    input  req_ready, busy, done, dbz, hi, lo
  );

  modport slave (
    input  req_valid, req_op, src1, src2, cancel,
    output req_ready, busy, done, dbz, hi, lo
  );
endinterface

// File: rtl/md_iter_core.sv
// md_iter_core: shared iterative datapath for the multiply/divide unit.
// A 2*WIDTH shift register performs one shift-add (multiply) or one
// restoring-subtract (divide) step per enabled cycle on unsigned magnitudes.
// step_res is the value the register would take on the next step; the
// parent commits it directly on the final step so the result is ready
// WIDTH edges after load.
module md_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,      // latch operands, start a new op
  input  logic               run,       // perform one step this edge
  input  logic               clear,     // abandon the op in flight
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,     // multiplier / dividend magnitude
  input  logic [WIDTH-1:0]   b_mag,     // multiplicand / divisor magnitude
  output logic               last,      // the next step is the final one
  output logic [2*WIDTH-1:0] step_res
);

  logic [2*WIDTH-1:0] acc;   // mul: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]   opnd;  // multiplicand or divisor
  logic               div_mode;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  // One step of each algorithm, selected by the latched mode
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch can be inferred.
    div_next  = '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    // Partial remainder shifted left with the next dividend bit, minus divisor.
    // A set top bit means borrow: restore (keep the shifted remainder), bit 0.
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (div_trial[WIDTH]) begin
      div_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
    step_res  = div_mode ? div_next : mul_next;
  end

  assign last = (cnt == CNT_W'(1));

  // Operand latch, step register and iteration counter
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: datapath registers are reset too, so a reset mid-op leaves no stale state visible.
    if (!resetn) begin
      acc      <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      acc      <= {{WIDTH{1'b0}}, a_mag};
      opnd     <= b_mag;
      div_mode <= is_div;
      cnt      <= CNT_W'(WIDTH);
    end else if (run && (cnt != '0)) begin
      acc <= step_res;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Handles the EXE handshake, sign fix-up, HI/LO writes and cancel.
// Optional build macro MD_FAST_MULT_EN: MULT/MULTU complete in one cycle
// through a combinational multiplier; division stays iterative.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic       clk,
  input logic       resetn,
  md_unit_if.slave  bus
);

  md_state_e          state;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  // Per-op context captured at accept
  logic               neg_q;     // negate product / quotient
  logic               neg_r;     // negate remainder (dividend negative)
  logic               div_zero;
  logic [WIDTH-1:0]   dividend;

  logic               accept;
  logic               op_signed;
  logic               is_mul_op;
  logic               is_div_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               in_iter;

  logic               core_load;
  logic               core_run;
  logic               core_clear;
  logic               core_last;
  logic [2*WIDTH-1:0] core_res;

  logic [2*WIDTH-1:0] mul_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign bus.req_ready = (state == ST_IDLE) & ~bus.cancel;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbz       = dbz_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

  assign accept    = bus.req_valid & bus.req_ready;
  assign op_signed = md_signed(bus.req_op);
  assign is_mul_op = md_is_mul(bus.req_op);
  assign is_div_op = md_is_div(bus.req_op);
  assign a_mag     = (op_signed & bus.src1[WIDTH-1]) ? -bus.src1 : bus.src1;
  assign b_mag     = (op_signed & bus.src2[WIDTH-1]) ? -bus.src2 : bus.src2;
  assign in_iter   = (state == ST_MUL) || (state == ST_DIV);

`ifdef MD_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  logic [2*WIDTH-1:0] fast_fix;

  assign core_load = accept & is_div_op;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign fast_fix  = (op_signed & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1])) ?
                     -fast_prod : fast_prod;
`else
  assign core_load = accept & (is_div_op | is_mul_op);
`endif
  assign core_run   = in_iter & ~bus.cancel;
  assign core_clear = in_iter & bus.cancel;

  md_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .resetn   (resetn),
    .load     (core_load),
    .run      (core_run),
    .clear    (core_clear),
    .is_div   (is_div_op),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .last     (core_last),
    .step_res (core_res)
  );

  // Sign fix-up of the final step; divide-by-zero overrides the quotient
  // and returns the untouched dividend as remainder.
  assign mul_fix  = neg_q ? -core_res : core_res;
  assign quot_fix = div_zero ? '1 :
                    (neg_q ? -core_res[WIDTH-1:0] : core_res[WIDTH-1:0]);
  assign rem_fix  = div_zero ? dividend :
                    (neg_r ? -core_res[2*WIDTH-1:WIDTH] : core_res[2*WIDTH-1:WIDTH]);

  // Handshake FSM with registered busy/done/dbz and the HI/LO registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      dividend <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            neg_q    <= op_signed & (bus.src1[WIDTH-1] ^ bus.src2[WIDTH-1]);
            neg_r    <= op_signed & bus.src1[WIDTH-1];
            div_zero <= (bus.src2 == '0);
            dividend <= bus.src1;
            case (bus.req_op)
              MD_MTHI: hi_q <= bus.src1;
              MD_MTLO: lo_q <= bus.src1;
              MD_MULT, MD_MULTU: begin
`ifdef MD_FAST_MULT_EN
                {hi_q, lo_q} <= fast_fix;
                state        <= ST_DONE;
                done_q       <= 1'b1;
`else
                state  <= ST_MUL;
                busy_q <= 1'b1;
`endif
              end
              MD_DIV, MD_DIVU: begin
                state  <= ST_DIV;
                busy_q <= 1'b1;
              end
              default: ;  // undefined op codes are accepted as no-ops
            endcase
          end
        end
        ST_MUL: begin
          if (bus.cancel) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (core_last) begin
            {hi_q, lo_q} <= mul_fix;
            state        <= ST_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        ST_DIV: begin
          if (bus.cancel) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (core_last) begin
            lo_q   <= quot_fix;
            hi_q   <= rem_fix;
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dbz_q  <= div_zero;
          end
        end
        ST_DONE: state <= ST_IDLE;  // result already committed; cancel ignored
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit (WIDTH=32).
// A behavioural model (HI/LO values from SV arithmetic, latency as a plain
// countdown) is compared against the DUT on every negative clock edge;
// directed cases pin the model with hand-computed literals, then a
// randomized phase exercises ops, cancels and corner operands.
// Build with +define+MD_FAST_MULT_EN to check the single-cycle multiplier.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int W = 32;
`ifdef MD_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks    = 0;
  int n_errors    = 0;
  int done_pulses = 0;

  // Behavioural model state
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_dbz  = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_hi   = '0;
  logic [31:0] p_lo   = '0;
  bit          p_dbz  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an op, straight from the arithmetic definition
  function automatic void calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l, output bit z);
    longint      p;
    logic [63:0] u;
    h = '0; l = '0; z = 1'b0;
    case (op)
      MD_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {h, l} = p;
      end
      MD_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        {h, l} = u;
      end
      MD_DIV: begin
        if (b == 32'h0) begin
          l = 32'hFFFF_FFFF; h = a; z = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'h0;
        end else begin
          l = $signed(a) / $signed(b);
          h = $signed(a) % $signed(b);
        end
      end
      MD_DIVU: begin
        if (b == 32'h0) begin
          l = 32'hFFFF_FFFF; h = a; z = 1'b1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Model update on every clock edge / async reset
  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
        m_hi = '0; m_lo = '0;
      end else begin
        bit rdy;
        rdy    = !m_busy && !m_done && !bus.cancel;
        m_done = 1'b0;
        m_dbz  = 1'b0;
        if (m_busy) begin
          if (bus.cancel) begin
            m_busy = 1'b0;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_busy = 1'b0;
              m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz; m_done = 1'b1;
            end
          end
        end else if (rdy && bus.req_valid) begin
          case (bus.req_op)
            MD_MTHI: m_hi = bus.src1;
            MD_MTLO: m_lo = bus.src1;
            MD_MULT, MD_MULTU: begin
              calc(bus.req_op, bus.src1, bus.src2, p_hi, p_lo, p_dbz);
`ifdef MD_FAST_MULT_EN
              m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
`else
              m_busy = 1'b1; m_left = W;
`endif
            end
            MD_DIV, MD_DIVU: begin
              calc(bus.req_op, bus.src1, bus.src2, p_hi, p_lo, p_dbz);
              m_busy = 1'b1; m_left = W;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Compare process: every output, every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) done_pulses++;
      check("req_ready", bus.req_ready, !m_busy && !m_done && !bus.cancel);
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("dbz",  bus.dbz,  m_dbz);
      check("hi",   bus.hi,   m_hi);
      check("lo",   bus.lo,   m_lo);
    end
  end

  // Present one op for a single accept edge; returns at accept edge + 2.
  // Operands are scrambled afterwards to prove they were latched.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    bus.req_valid = 1'b1; bus.req_op = op; bus.src1 = a; bus.src2 = b;
    @(posedge clk); #2;
    bus.req_valid = 1'b0; bus.src1 = $urandom; bus.src2 = $urandom;
  endtask

  // Wait (bounded) for done; first negedge after accept counts as cycle 1
  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 200 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) lat = i;
    end
    check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 200 && ok == 0; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) ok = 1;
    end
    check("idle_timeout", ok, 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int pulses_before;
    bus.req_valid = 1'b0; bus.req_op = MD_MULT;
    bus.src1 = '0; bus.src2 = '0; bus.cancel = 1'b0;

    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ready", bus.req_ready, 1'b1);

    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_7_m2", DIV_LAT);
    check("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_7_m2_hi", bus.hi, 32'h0000_0001);
    check("div_7_m2_dbz", bus.dbz, 1'b0);

    issue(MD_DIVU, 32'hFFFF_FFFF, 32'h10);
    wait_done("divu_big", DIV_LAT);
    check("divu_big_lo", bus.lo, 32'h0FFF_FFFF);
    check("divu_big_hi", bus.hi, 32'h0000_000F);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", DIV_LAT);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0);
    check("div_ovf_dbz", bus.dbz, 1'b0);

    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_m3_5", MUL_LAT);
    check("mult_m3_5_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", MUL_LAT);
    check("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", bus.lo, 32'h0000_0001);

    issue(MD_DIV, 32'h1234, 32'h0);
    wait_done("div_zero", DIV_LAT);
    check("div_zero_lo", bus.lo, 32'hFFFF_FFFF);
    check("div_zero_hi", bus.hi, 32'h0000_1234);
    check("div_zero_dbz", bus.dbz, 1'b1);

    pulses_before = done_pulses;
    issue(MD_MTHI, 32'hA5A5_A5A5, 32'h0);
    @(negedge clk);
    check("mthi_hi", bus.hi, 32'hA5A5_A5A5);
    check("mthi_lo", bus.lo, 32'hFFFF_FFFF);
    check("mthi_no_done", done_pulses, pulses_before);

    // MTLO presented together with cancel while idle must be dropped
    @(posedge clk); #2;
    bus.req_valid = 1'b1; bus.req_op = MD_MTLO; bus.src1 = 32'h1111_2222; bus.cancel = 1'b1;
    @(posedge clk); #2;
    bus.req_valid = 1'b0; bus.cancel = 1'b0;
    @(negedge clk);
    check("mtlo_cancel_lo", bus.lo, 32'hFFFF_FFFF);

    // Cancel a DIVU mid-flight
    pulses_before = done_pulses;
    issue(MD_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2 bus.cancel = 1'b1;
    @(posedge clk); #2 bus.cancel = 1'b0;
    @(negedge clk);
    check("cancel_ready", bus.req_ready, 1'b1);
    check("cancel_busy", bus.busy, 1'b0);
    check("cancel_hi", bus.hi, 32'hA5A5_A5A5);
    check("cancel_lo", bus.lo, 32'hFFFF_FFFF);
    repeat (40) @(negedge clk);
    check("cancel_no_done", done_pulses, pulses_before);

    // Undefined op code is a no-op
    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    @(negedge clk);
    check("undef_done", bus.done, 1'b0);
    check("undef_hi", bus.hi, 32'hA5A5_A5A5);
    check("undef_ready", bus.req_ready, 1'b1);

    // Reset in the middle of a MULT
    issue(MD_MULT, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_hi", bus.hi, 32'h0);
    check("midrst_lo", bus.lo, 32'h0);
    check("midrst_busy", bus.busy, 1'b0);
    @(posedge clk); #2 resetn = 1'b1;

    issue(MD_DIVU, 32'd100, 32'd7);
    wait_done("divu_100_7", DIV_LAT);
    check("divu_100_7_lo", bus.lo, 32'd14);
    check("divu_100_7_hi", bus.hi, 32'd2);

    // Randomized traffic; the compare process checks every cycle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #2;
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_op    = 3'($urandom_range(0, 7));
      bus.src1      = pick();
      bus.src2      = pick();
      bus.cancel    = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #2;
    bus.req_valid = 1'b0; bus.cancel = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
